// File: rtl/tlp_mux_pkg.sv
// Shared constants for the transaction-layer routing mux: link-state encodings,
// the default forwarding mask and the header destination-field extractor.
package tlp_mux_pkg;

   localparam logic [3:0] ST_RESET  = 4'b0001;
   localparam logic [3:0] ST_INIT   = 4'b0010;
   localparam logic [3:0] ST_IDLE   = 4'b0100;
   localparam logic [3:0] ST_ACTIVE = 4'b1000;

   localparam logic [3:0] DEFAULT_PASS_MASK = ST_INIT | ST_IDLE | ST_ACTIVE;

   // Words are zero-extended to 64 bits so one function serves every DATA_W.
   function automatic int dest_field(input logic [63:0] word, input int lsb, input int width);
      logic [63:0] field;
      field = (word >> lsb) & ((64'd1 << width) - 64'd1);
      return int'(field[31:0]);
   endfunction

endpackage

// File: rtl/tlp_route_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// N must be a power of two so the index arithmetic wraps on its own.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = ptr + PTR_W'(k);
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/tlp_route_mux.sv
// NUM_PORTS x NUM_PORTS transaction-layer routing mux with per-output round-robin
// arbitration, a one-entry registered output stage and link-state gating/flush.
module tlp_route_mux
   import tlp_mux_pkg::*;
#(
   parameter int                   NUM_PORTS = 4,
   parameter int                   DATA_W    = 10,
   parameter int                   DEST_LSB  = 8,
   parameter int                   DEST_W    = 2,
   parameter int                   STATE_W   = 4,
   parameter logic [STATE_W-1:0]   PASS_MASK = DEFAULT_PASS_MASK,
   parameter logic [STATE_W-1:0]   FLUSH_ST  = ST_RESET
) (
   input  logic                          clk,
   input  logic                          reset_L,
   input  logic [STATE_W-1:0]            state,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS-1:0]          in_valid,
   output logic [NUM_PORTS-1:0]          in_ready,
   output logic [NUM_PORTS*DATA_W-1:0]   out_data,
   output logic [NUM_PORTS-1:0]          out_valid,
   input  logic [NUM_PORTS-1:0]          out_ready
);

   logic [NUM_PORTS-1:0][DATA_W-1:0]    in_word;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0][DEST_W-1:0]    grant_idx;
   logic [NUM_PORTS-1:0]                load;
   logic                                flush;
   logic                                pass;

   assign in_word = in_data;
   assign flush   = (state == FLUSH_ST);
   assign pass    = (|(state & PASS_MASK)) && !flush;

   // req[j][i]: input i wants output j. Each input names exactly one output.
   always_comb begin
      req = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            req[j][i] = in_valid[i] && pass &&
                        (dest_field(64'(in_word[i]), DEST_LSB, DEST_W) == j);
         end
      end
   end

   // An input is ready when its output granted it and that register can load.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            in_ready[i] = in_ready[i] | (grant[j][i] & load[j]);
         end
      end
      in_ready = in_ready & {NUM_PORTS{reset_L}};
   end

   for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
      logic [DATA_W-1:0] data_q;
      logic              valid_q;
      logic [DEST_W-1:0] ptr_q;
      logic              xfer;

      rr_arbiter #(.N(NUM_PORTS), .PTR_W(DEST_W)) u_arb (
         .req       (req[j]),
         .ptr       (ptr_q),
         .grant     (grant[j]),
         .grant_idx (grant_idx[j])
      );

      assign load[j] = ~valid_q | out_ready[j];
      assign xfer    = (|grant[j]) & load[j];

      // NOTE: the output data register is reset too, so a flushed or freshly reset port reads back as zero.
      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
            data_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
         end else if (flush) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
         end else if (xfer) begin
            data_q  <= in_word[grant_idx[j]];
            valid_q <= 1'b1;
            ptr_q   <= grant_idx[j] + DEST_W'(1);
         end else if (out_ready[j]) begin
            valid_q <= 1'b0;
         end
      end

      assign out_data[j*DATA_W +: DATA_W] = data_q;
      assign out_valid[j]                 = valid_q;
   end

endmodule

// File: tb/tb_tlp_route_mux.sv
// Self-checking bench for tlp_route_mux: directed scenarios plus randomized
// traffic checked every cycle against a behavioural model of the routing rules.
module tb_tlp_route_mux;

   localparam int N  = 4;
   localparam int DW = 10;

   logic            clk = 1'b0;
   logic            reset_L;
   logic [3:0]      state;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] out_data;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready;

   int checks   = 0;
   int failures = 0;

   // Model: per-output "next preferred input", register contents and valid flags.
   int            m_ptr [N];
   logic          m_ov  [N];
   logic [DW-1:0] m_od  [N];
   logic [N-1:0]  last_acc;

   always #5 clk = ~clk;

   tlp_route_mux dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .state     (state),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   function automatic logic [DW-1:0] word_in(input int i);
      return in_data[i*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] word_out(input int j);
      return out_data[j*DW +: DW];
   endfunction

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         m_ptr[j] = 0;
         m_ov[j]  = 1'b0;
         m_od[j]  = '0;
      end
   endtask

   // One clock: compare DUT against model (just after negedge), advance model at posedge.
   task automatic cycle(input string tag);
      logic [N-1:0]    er;
      logic [N-1:0]    ev;
      logic [N*DW-1:0] ed;
      logic [DW-1:0]   w;
      int              win  [N];
      bit              ld   [N];
      int              best;
      int              d;
      bit              pass;
      #1;
      pass = ((state & 4'b1110) != 4'b0000) && (state != 4'b0001);
      er = '0;
      for (int j = 0; j < N; j++) begin
         ld[j]  = !m_ov[j] || out_ready[j];
         win[j] = -1;
         best   = N;
         for (int i = 0; i < N; i++) begin
            w = word_in(i);
            if (pass && in_valid[i] && int'(w[9:8]) == j) begin
               d = (i - m_ptr[j] + N) % N;
               if (d < best) begin
                  best   = d;
                  win[j] = i;
               end
            end
         end
         if (reset_L && win[j] >= 0 && ld[j]) er[win[j]] = 1'b1;
      end
      for (int j = 0; j < N; j++) begin
         ev[j]            = m_ov[j];
         ed[j*DW +: DW]   = m_od[j];
      end
      checks++;
      if (in_ready !== er) begin
         failures++;
         $display("FAIL %s in_ready got=%b exp=%b t=%0t", tag, in_ready, er, $time);
      end
      checks++;
      if (out_valid !== ev) begin
         failures++;
         $display("FAIL %s out_valid got=%b exp=%b t=%0t", tag, out_valid, ev, $time);
      end
      checks++;
      if (out_data !== ed) begin
         failures++;
         $display("FAIL %s out_data got=%h exp=%h t=%0t", tag, out_data, ed, $time);
      end
      last_acc = er;
      @(posedge clk);
      if (reset_L) begin
         if (state == 4'b0001) begin
            model_reset();
         end else begin
            for (int j = 0; j < N; j++) begin
               if (win[j] >= 0 && ld[j]) begin
                  m_od[j]  = word_in(win[j]);
                  m_ov[j]  = 1'b1;
                  m_ptr[j] = (win[j] + 1) % N;
               end else if (out_ready[j]) begin
                  m_ov[j] = 1'b0;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset from a negedge; outputs must clear without waiting for a clock.
   task automatic apply_reset(input int cycles);
      reset_L = 1'b0;
      #1;
      checks++;
      if (out_valid !== '0 || out_data !== '0) begin
         failures++;
         $display("FAIL async_reset got valid=%b data=%h exp valid=0 data=0", out_valid, out_data);
      end
      model_reset();
      for (int c = 0; c < cycles; c++) cycle("reset_hold");
      reset_L  = 1'b1;
      in_valid = '0;
   endtask

   task automatic test_reset();
      in_valid  = 4'hF;
      in_data   = {10'b1100000001, 10'b1000000010, 10'b0100000011, 10'b0000000100};
      out_ready = 4'hF;
      state     = 4'b1000;
      apply_reset(3);
      cycle("reset_release");
   endtask

   task automatic test_single_route();
      apply_reset(1);
      state     = 4'b0010;
      out_ready = 4'hF;
      in_data   = '0;
      in_data[9:0] = 10'b0100000011;
      in_valid  = 4'b0001;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_in_ready got=%b exp=0001", in_ready);
      end
      cycle("single");
      in_valid = '0;
      checks++;
      if (out_valid !== 4'b0010 || word_out(1) !== 10'b0100000011) begin
         failures++;
         $display("FAIL single_out got valid=%b out1=%b exp valid=0010 out1=0100000011",
                  out_valid, word_out(1));
      end
      cycle("single_drain");
   endtask

   task automatic test_contention();
      logic [DW-1:0] exp_seq [3];
      exp_seq[0] = 10'b1100000000;
      exp_seq[1] = 10'b1100000010;
      exp_seq[2] = 10'b1100000011;
      apply_reset(1);
      state     = 4'b1000;
      out_ready = 4'hF;
      in_data   = {exp_seq[2], exp_seq[1], 10'b0000000000, exp_seq[0]};
      in_valid  = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         cycle("contend");
         in_valid = in_valid & ~last_acc;
         checks++;
         if (out_valid[3] !== 1'b1 || word_out(3) !== exp_seq[k]) begin
            failures++;
            $display("FAIL contend_order k=%0d got v=%b d=%b exp v=1 d=%b",
                     k, out_valid[3], word_out(3), exp_seq[k]);
         end
      end
      // Pointer has wrapped back to 0, so in0 beats in3.
      in_valid = 4'b1001;
      cycle("contend_ptr");
      in_valid = '0;
      checks++;
      if (word_out(3) !== exp_seq[0]) begin
         failures++;
         $display("FAIL contend_ptr_wrap got=%b exp=%b", word_out(3), exp_seq[0]);
      end
      cycle("contend_drain");
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] wa, wb;
      wa = 10'b1000000010;
      wb = 10'b1000000101;
      apply_reset(1);
      state     = 4'b1000;
      out_ready = 4'b1011;
      in_data   = '0;
      in_data[19:10] = wa;
      in_valid  = 4'b0010;
      cycle("bp_first");
      in_data[19:10] = wb;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (in_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall_ready k=%0d got=%b exp=0", k, in_ready[1]);
         end
         cycle("bp_stall");
         checks++;
         if (out_valid[2] !== 1'b1 || word_out(2) !== wa) begin
            failures++;
            $display("FAIL bp_hold k=%0d got v=%b d=%b exp v=1 d=%b", k, out_valid[2], word_out(2), wa);
         end
      end
      out_ready = 4'hF;
      #1;
      checks++;
      if (in_ready[1] !== 1'b1) begin
         failures++;
         $display("FAIL bp_refill_ready got=%b exp=1", in_ready[1]);
      end
      cycle("bp_refill");
      in_valid = '0;
      checks++;
      if (out_valid[2] !== 1'b1 || word_out(2) !== wb) begin
         failures++;
         $display("FAIL bp_refill got v=%b d=%b exp v=1 d=%b", out_valid[2], word_out(2), wb);
      end
      cycle("bp_drain");
   endtask

   task automatic test_gating_flush();
      apply_reset(1);
      state     = 4'b0010;
      out_ready = 4'b0000;
      in_data   = '0;
      in_data[29:20] = 10'b0100000111;
      in_valid  = 4'b0100;
      cycle("gate_fill");
      in_valid  = '0;
      state     = 4'b0001;
      in_data[9:0]   = 10'b0100001000;
      in_data[39:30] = 10'b0100001111;
      in_valid  = 4'b1001;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL flush_in_ready got=%b exp=0000", in_ready);
      end
      cycle("flush");
      checks++;
      if (out_valid !== 4'b0000 || word_out(1) !== 10'd0) begin
         failures++;
         $display("FAIL flush_clear got v=%b out1=%b exp v=0000 out1=0", out_valid, word_out(1));
      end
      state     = 4'b0100;
      out_ready = 4'hF;
      cycle("resume");
      in_valid = in_valid & ~last_acc;
      checks++;
      if (out_valid[1] !== 1'b1 || word_out(1) !== 10'b0100001000) begin
         failures++;
         $display("FAIL resume_ptr0 got v=%b out1=%b exp v=1 out1=0100001000", out_valid[1], word_out(1));
      end
      cycle("resume2");
      in_valid = '0;
      cycle("resume_drain");
   endtask

   task automatic test_parallel();
      logic [N*DW-1:0] words;
      words = {10'b0100000100, 10'b0000000011, 10'b1100000010, 10'b1000000001};
      apply_reset(1);
      state     = 4'b1000;
      out_ready = 4'hF;
      in_data   = words;
      in_valid  = 4'hF;
      #1;
      checks++;
      if (in_ready !== 4'hF) begin
         failures++;
         $display("FAIL parallel_ready got=%b exp=1111", in_ready);
      end
      cycle("parallel");
      in_valid = '0;
      checks++;
      if (out_valid !== 4'hF ||
          word_out(0) !== words[29:20] || word_out(1) !== words[39:30] ||
          word_out(2) !== words[9:0]   || word_out(3) !== words[19:10]) begin
         failures++;
         $display("FAIL parallel_out got v=%b d=%h exp v=1111", out_valid, out_data);
      end
      cycle("parallel_drain");
   endtask

   task automatic test_random();
      logic [3:0] st_tbl [6];
      st_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100};
      apply_reset(1);
      state    = 4'b1000;
      last_acc = '0;
      in_valid = '0;
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            apply_reset(2);
            last_acc = '0;
         end
         if (c % 8 == 0) state = st_tbl[$urandom_range(0, 5)];
         out_ready = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            if (!in_valid[i] || last_acc[i]) begin
               in_valid[i]         = ($urandom_range(0, 3) != 0);
               in_data[i*DW +: DW] = DW'($urandom);
            end
         end
         cycle("random");
      end
      in_valid = '0;
   endtask

   initial begin
      reset_L   = 1'b0;
      state     = 4'b0010;
      in_data   = '0;
      in_valid  = '0;
      out_ready = '0;
      last_acc  = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_route();
      test_contention();
      test_backpressure();
      test_gating_flush();
      test_parallel();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
